glb_core_proc_switch: RTL and testbench
=======================================

Name: glb_core_proc_switch

Overview:
Per-tile switch that consumes the write and read-request packets the processor router delivers for this tile. It decodes the tile, bank and offset fields of each packet and drives the tile's single-port banks. It tracks in-flight bank reads and returns read data to the processor router as a registered response packet. It sits between the processor router and the bank array inside glb_core.

Parameters:
TILE_SEL_ADDR_WIDTH, 4, width of tile-select field and glb_tile_id
BANKS_PER_TILE, 2, banks per tile (power of 2); BANK_SEL_WIDTH = clog2(BANKS_PER_TILE)
BANK_ADDR_WIDTH, 17, byte offset within a bank
BANK_DATA_WIDTH, 64, data word width; strobe width = BANK_DATA_WIDTH/8
BANK_RD_LATENCY, 3, cycles from bank_rd_en to valid bank_rd_data (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
glb_tile_id  in  TILE_SEL_ADDR_WIDTH  this tile's id
wr_packet_pr2sw  in  wr_packet_t  {wr_en, wr_strb, wr_addr, wr_data} from processor router
rdrq_packet_pr2sw  in  rdrq_packet_t  {rd_en, rd_addr} from processor router
rdrs_packet_sw2pr  out  rdrs_packet_t  {rd_data, rd_data_valid} to processor router
bank_wr_en  out  BANKS_PER_TILE  one-hot per-bank write enable
bank_wr_strb  out  BANK_DATA_WIDTH/8  shared byte strobe
bank_wr_addr  out  BANK_ADDR_WIDTH  shared write offset
bank_wr_data  out  BANK_DATA_WIDTH  shared write data
bank_rd_en  out  BANKS_PER_TILE  one-hot per-bank read enable
bank_rd_addr  out  BANK_ADDR_WIDTH  shared read offset
bank_rd_data  in  BANKS_PER_TILE*BANK_DATA_WIDTH  bank b data at slice b
err_collision  out  1  sticky: a read was dropped due to a same-bank write

Behaviour:
- One clock, clk. Reset is synchronous and active-high: all outputs and all internal state clear to 0 on the first clk edge with reset high.
- Address map, MSB to LSB: [tile | bank | offset]. GLB_ADDR_WIDTH = TILE_SEL_ADDR_WIDTH + BANK_SEL_WIDTH + BANK_ADDR_WIDTH.
- A packet is accepted only when its enable is high and its tile field equals glb_tile_id. Non-matching packets are ignored silently.
- Write path: an accepted write drives its bank_wr_en bit, strb, offset and data, registered one cycle later. Write latency is 1. Outputs are 0 in cycles with no accepted write.
- Read path: an accepted read drives its bank_rd_en bit and bank_rd_addr, registered one cycle later.
- In-flight tracking: a BANK_RD_LATENCY-deep shift register of {valid, bank_sel} advances every cycle.
- At the tail of the shift register, the selected bank_rd_data slice is registered into rdrs_packet_sw2pr.rd_data with rd_data_valid = 1 for exactly one cycle.
- Total read latency, request packet to response valid, is BANK_RD_LATENCY + 2 cycles.
- Throughput is one read per cycle. Back-to-back reads give back-to-back valid responses in request order. No backpressure exists.
- When rd_data_valid is 0, rd_data holds its last value and is don't-care.
- Simultaneous accepted write and read, same bank: the write executes, the read is dropped (no bank_rd_en, no response), and err_collision sets. err_collision clears only on reset.
- Simultaneous accepted write and read, different banks: both execute in the same cycle.
- Reset while reads are in flight: the shift register is cleared, so no response is ever emitted for those reads.

Decomposition:
- global_buffer_pkg holds wr_packet_t, rdrq_packet_t and rdrs_packet_t.
- global_buffer_param holds the parameter defaults plus GLB_ADDR_WIDTH and BANK_SEL_WIDTH.
- One natural sub-module: glb_core_rd_tracker, holding the in-flight shift register, the bank-data mux and the response register.

Test Plan:
All addresses below assume glb_tile_id=3 and default parameters; address 0xE0010 decodes to tile 3, bank 1, offset 0x10.
- Reset: hold reset 2 cycles with random inputs -> all outputs 0, including err_collision.
- Write: wr_en=1, wr_addr=0xE0010, wr_strb=0xFF, wr_data=0xDEADBEEF_01234567 -> next cycle bank_wr_en=2'b10, bank_wr_addr=0x10, strb and data match; bank_wr_en=0 the cycle after.
- Read: rd_addr=0xC0008 (bank 0, offset 0x08), bank 0 returns 0xA5A5 at its latency -> bank_rd_en=2'b01 at cycle+1; rd_data_valid=1 with rd_data=0xA5A5 at cycle+5, for one cycle.
- Streaming: 4 consecutive reads alternating banks 0/1, each bank returning a distinct pattern -> 4 consecutive valid cycles, data in request order, no gaps.
- Tile mismatch: write and read to 0x20010 (tile 0) -> no bank enables, no response, err_collision stays 0.
- Collision: write to 0xE0000 and read to 0xE0040 in the same cycle -> write performed, no bank_rd_en, no response, err_collision=1 until reset. Repeat with the read at 0xC0040 -> both execute and err_collision is unchanged.
- Reset mid-flight: assert reset 2 cycles after a read is accepted -> rd_data_valid never asserts for that read.

Source files
------------

// File: rtl/global_buffer_param.sv
// Default sizing for the global buffer core and the address-field widths derived from it.
package global_buffer_param;

    localparam int TILE_SEL_ADDR_WIDTH = 4;
    localparam int BANKS_PER_TILE      = 2;
    localparam int BANK_SEL_WIDTH      = $clog2(BANKS_PER_TILE);
    localparam int BANK_ADDR_WIDTH     = 17;
    localparam int BANK_DATA_WIDTH     = 64;
    localparam int BANK_STRB_WIDTH     = BANK_DATA_WIDTH / 8;
    localparam int BANK_RD_LATENCY     = 3;
    localparam int GLB_ADDR_WIDTH      = TILE_SEL_ADDR_WIDTH + BANK_SEL_WIDTH + BANK_ADDR_WIDTH;

endpackage

// File: rtl/global_buffer_pkg.sv
// Packet types exchanged with the processor router and helpers that split a global address.
package global_buffer_pkg;

    import global_buffer_param::*;

    typedef struct packed {
        logic                       wr_en;
        logic [BANK_STRB_WIDTH-1:0] wr_strb;
        logic [GLB_ADDR_WIDTH-1:0]  wr_addr;
        logic [BANK_DATA_WIDTH-1:0] wr_data;
    } wr_packet_t;

    typedef struct packed {
        logic                      rd_en;
        logic [GLB_ADDR_WIDTH-1:0] rd_addr;
    } rdrq_packet_t;

    typedef struct packed {
        logic [BANK_DATA_WIDTH-1:0] rd_data;
        logic                       rd_data_valid;
    } rdrs_packet_t;

    // Address layout, MSB to LSB: [tile | bank | offset].
    function automatic logic [TILE_SEL_ADDR_WIDTH-1:0] addr_tile(input logic [GLB_ADDR_WIDTH-1:0] addr);
        return addr[GLB_ADDR_WIDTH-1 -: TILE_SEL_ADDR_WIDTH];
    endfunction

    function automatic logic [BANK_SEL_WIDTH-1:0] addr_bank(input logic [GLB_ADDR_WIDTH-1:0] addr);
        return addr[BANK_ADDR_WIDTH +: BANK_SEL_WIDTH];
    endfunction

    function automatic logic [BANK_ADDR_WIDTH-1:0] addr_offset(input logic [GLB_ADDR_WIDTH-1:0] addr);
        return addr[BANK_ADDR_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/glb_core_rd_tracker.sv
// Follows issued bank reads through the bank latency and registers the returning word
// as a one-cycle-valid response packet.
module glb_core_rd_tracker
    import global_buffer_param::*;
    import global_buffer_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic                                      rd_issue_valid,
    input  logic [BANK_SEL_WIDTH-1:0]                 rd_issue_bank,
    input  logic [BANKS_PER_TILE*BANK_DATA_WIDTH-1:0] bank_rd_data,
    output rdrs_packet_t                              rdrs_packet
);

    typedef struct packed {
        logic                      valid;
        logic [BANK_SEL_WIDTH-1:0] bank;
    } inflight_t;

    inflight_t    pipe_q [BANK_RD_LATENCY];
    inflight_t    pipe_d [BANK_RD_LATENCY];
    rdrs_packet_t rdrs_q;
    rdrs_packet_t rdrs_d;
    inflight_t    tail_s;

    // Stage 0 is loaded from the cycle the bank sees its read enable, so the tail
    // lines up with the cycle the bank data is valid.
    always_comb begin
        pipe_d[0] = '{valid: rd_issue_valid, bank: rd_issue_bank};
        for (int i = 1; i < BANK_RD_LATENCY; i++) begin
            pipe_d[i] = pipe_q[i-1];
        end
        tail_s = pipe_q[BANK_RD_LATENCY-1];
        rdrs_d = rdrs_q;
        rdrs_d.rd_data_valid = tail_s.valid;
        if (tail_s.valid) begin
            rdrs_d.rd_data = bank_rd_data[tail_s.bank*BANK_DATA_WIDTH +: BANK_DATA_WIDTH];
        end else begin
            rdrs_d.rd_data = rdrs_q.rd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < BANK_RD_LATENCY; i++) begin
                pipe_q[i] <= '0;
            end
            rdrs_q <= '0;
        end else begin
            for (int i = 0; i < BANK_RD_LATENCY; i++) begin
                pipe_q[i] <= pipe_d[i];
            end
            rdrs_q <= rdrs_d;
        end
    end

    assign rdrs_packet = rdrs_q;

endmodule

// File: rtl/glb_core_proc_switch.sv
// Per-tile switch: decodes processor-router write/read packets onto the tile's banks and
// returns read data through the in-flight tracker.
module glb_core_proc_switch
    import global_buffer_param::*;
    import global_buffer_pkg::*;
(
    input  logic                                      clk,
    input  logic                                      reset,
    input  logic [TILE_SEL_ADDR_WIDTH-1:0]            glb_tile_id,
    input  wr_packet_t                                wr_packet_pr2sw,
    input  rdrq_packet_t                              rdrq_packet_pr2sw,
    output rdrs_packet_t                              rdrs_packet_sw2pr,
    output logic [BANKS_PER_TILE-1:0]                 bank_wr_en,
    output logic [BANK_STRB_WIDTH-1:0]                bank_wr_strb,
    output logic [BANK_ADDR_WIDTH-1:0]                bank_wr_addr,
    output logic [BANK_DATA_WIDTH-1:0]                bank_wr_data,
    output logic [BANKS_PER_TILE-1:0]                 bank_rd_en,
    output logic [BANK_ADDR_WIDTH-1:0]                bank_rd_addr,
    input  logic [BANKS_PER_TILE*BANK_DATA_WIDTH-1:0] bank_rd_data,
    output logic                                      err_collision
);

    logic                       wr_acc_s;
    logic                       rd_acc_s;
    logic                       collide_s;
    logic [BANK_SEL_WIDTH-1:0]  wr_bank_s;
    logic [BANK_SEL_WIDTH-1:0]  rd_bank_s;

    logic [BANKS_PER_TILE-1:0]  bank_wr_en_d,   bank_wr_en_q;
    logic [BANK_STRB_WIDTH-1:0] bank_wr_strb_d, bank_wr_strb_q;
    logic [BANK_ADDR_WIDTH-1:0] bank_wr_addr_d, bank_wr_addr_q;
    logic [BANK_DATA_WIDTH-1:0] bank_wr_data_d, bank_wr_data_q;
    logic [BANKS_PER_TILE-1:0]  bank_rd_en_d,   bank_rd_en_q;
    logic [BANK_ADDR_WIDTH-1:0] bank_rd_addr_d, bank_rd_addr_q;
    logic [BANK_SEL_WIDTH-1:0]  rd_bank_d,      rd_bank_q;
    logic                       err_d,          err_q;

    // Same-bank write/read in one cycle: the single-port bank takes the write, the read is dropped.
    always_comb begin
        wr_bank_s = addr_bank(wr_packet_pr2sw.wr_addr);
        rd_bank_s = addr_bank(rdrq_packet_pr2sw.rd_addr);
        wr_acc_s  = wr_packet_pr2sw.wr_en && (addr_tile(wr_packet_pr2sw.wr_addr) == glb_tile_id);
        rd_acc_s  = rdrq_packet_pr2sw.rd_en && (addr_tile(rdrq_packet_pr2sw.rd_addr) == glb_tile_id);
        collide_s = wr_acc_s && rd_acc_s && (wr_bank_s == rd_bank_s);

        bank_wr_en_d   = '0;
        bank_wr_strb_d = '0;
        bank_wr_addr_d = '0;
        bank_wr_data_d = '0;
        bank_rd_en_d   = '0;
        bank_rd_addr_d = '0;
        rd_bank_d      = '0;
        err_d          = err_q | collide_s;

        if (wr_acc_s) begin
            bank_wr_en_d[wr_bank_s] = 1'b1;
            bank_wr_strb_d          = wr_packet_pr2sw.wr_strb;
            bank_wr_addr_d          = addr_offset(wr_packet_pr2sw.wr_addr);
            bank_wr_data_d          = wr_packet_pr2sw.wr_data;
        end else begin
            bank_wr_en_d = '0;
        end

        if (rd_acc_s && !collide_s) begin
            bank_rd_en_d[rd_bank_s] = 1'b1;
            bank_rd_addr_d          = addr_offset(rdrq_packet_pr2sw.rd_addr);
            rd_bank_d               = rd_bank_s;
        end else begin
            bank_rd_en_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bank_wr_en_q   <= '0;
            bank_wr_strb_q <= '0;
            bank_wr_addr_q <= '0;
            bank_wr_data_q <= '0;
            bank_rd_en_q   <= '0;
            bank_rd_addr_q <= '0;
            rd_bank_q      <= '0;
            err_q          <= 1'b0;
        end else begin
            bank_wr_en_q   <= bank_wr_en_d;
            bank_wr_strb_q <= bank_wr_strb_d;
            bank_wr_addr_q <= bank_wr_addr_d;
            bank_wr_data_q <= bank_wr_data_d;
            bank_rd_en_q   <= bank_rd_en_d;
            bank_rd_addr_q <= bank_rd_addr_d;
            rd_bank_q      <= rd_bank_d;
            err_q          <= err_d;
        end
    end

    glb_core_rd_tracker u_rd_tracker (
        .clk            (clk),
        .reset          (reset),
        .rd_issue_valid (|bank_rd_en_q),
        .rd_issue_bank  (rd_bank_q),
        .bank_rd_data   (bank_rd_data),
        .rdrs_packet    (rdrs_packet_sw2pr)
    );

    assign bank_wr_en    = bank_wr_en_q;
    assign bank_wr_strb  = bank_wr_strb_q;
    assign bank_wr_addr  = bank_wr_addr_q;
    assign bank_wr_data  = bank_wr_data_q;
    assign bank_rd_en    = bank_rd_en_q;
    assign bank_rd_addr  = bank_rd_addr_q;
    assign err_collision = err_q;

endmodule

// File: tb/tb_glb_core_proc_switch.sv
// Directed bench for glb_core_proc_switch: vector table plus hand-written streaming,
// reset and mid-flight reset sequences, against a small 3-cycle bank model.
module tb_glb_core_proc_switch;

    import global_buffer_param::*;
    import global_buffer_pkg::*;

    logic                                      clk;
    logic                                      reset;
    logic [TILE_SEL_ADDR_WIDTH-1:0]            glb_tile_id;
    wr_packet_t                                wr_pkt;
    rdrq_packet_t                              rd_pkt;
    rdrs_packet_t                              rs_pkt;
    logic [BANKS_PER_TILE-1:0]                 bank_wr_en;
    logic [BANK_STRB_WIDTH-1:0]                bank_wr_strb;
    logic [BANK_ADDR_WIDTH-1:0]                bank_wr_addr;
    logic [BANK_DATA_WIDTH-1:0]                bank_wr_data;
    logic [BANKS_PER_TILE-1:0]                 bank_rd_en;
    logic [BANK_ADDR_WIDTH-1:0]                bank_rd_addr;
    logic [BANKS_PER_TILE*BANK_DATA_WIDTH-1:0] bank_rd_data;
    logic                                      err_collision;

    int checks = 0;
    int errors = 0;

    glb_core_proc_switch dut (
        .clk               (clk),
        .reset             (reset),
        .glb_tile_id       (glb_tile_id),
        .wr_packet_pr2sw   (wr_pkt),
        .rdrq_packet_pr2sw (rd_pkt),
        .rdrs_packet_sw2pr (rs_pkt),
        .bank_wr_en        (bank_wr_en),
        .bank_wr_strb      (bank_wr_strb),
        .bank_wr_addr      (bank_wr_addr),
        .bank_wr_data      (bank_wr_data),
        .bank_rd_en        (bank_rd_en),
        .bank_rd_addr      (bank_rd_addr),
        .bank_rd_data      (bank_rd_data),
        .err_collision     (err_collision)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bank model content: bank 0 offset 0x08 holds 0xA5A5, everything else is {B00b, offset}.
    function automatic logic [63:0] bank_val(input int b, input logic [16:0] off);
        if (b == 0 && off == 17'h8) return 64'hA5A5;
        return {16'hB000 + 16'(b), 31'd0, off};
    endfunction

    logic [BANKS_PER_TILE-1:0]  en_p   [3];
    logic [BANK_ADDR_WIDTH-1:0] addr_p [3];

    always @(posedge clk) begin
        en_p[0]   <= bank_rd_en;
        addr_p[0] <= bank_rd_addr;
        en_p[1]   <= en_p[0];
        addr_p[1] <= addr_p[0];
        en_p[2]   <= en_p[1];
        addr_p[2] <= addr_p[1];
    end

    always_comb begin
        bank_rd_data = '0;
        for (int b = 0; b < BANKS_PER_TILE; b++) begin
            bank_rd_data[b*64 +: 64] = (en_p[2][b] === 1'b1) ? bank_val(b, addr_p[2]) : 64'h0;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wr_pkt = '0;
        rd_pkt = '0;
    endtask

    typedef struct {
        logic        we;
        logic [21:0] wa;
        logic [7:0]  ws;
        logic [63:0] wd;
        logic        re;
        logic [21:0] ra;
        logic [1:0]  x_wen;
        logic [16:0] x_waddr;
        logic [1:0]  x_ren;
        logic [16:0] x_raddr;
        logic        x_rv;
        logic [63:0] x_rdata;
        logic        x_err;
    } vec_t;

    vec_t vecs [9];

    logic [63:0] stream_exp [4];
    logic [21:0] stream_addr [4];
    logic        seen_valid;

    initial begin
        vecs[0] = '{1'b1, 22'hE0010, 8'hFF, 64'hDEADBEEF_01234567, 1'b0, 22'h0,
                    2'b10, 17'h10, 2'b00, 17'h0, 1'b0, 64'h0, 1'b0};
        vecs[1] = '{1'b0, 22'h0, 8'h0, 64'h0, 1'b1, 22'hC0008,
                    2'b00, 17'h0, 2'b01, 17'h8, 1'b1, 64'hA5A5, 1'b0};
        vecs[2] = '{1'b0, 22'h0, 8'h0, 64'h0, 1'b1, 22'hE0020,
                    2'b00, 17'h0, 2'b10, 17'h20, 1'b1, 64'hB001_0000_0000_0020, 1'b0};
        vecs[3] = '{1'b1, 22'hC0100, 8'h0F, 64'h11223344_55667788, 1'b0, 22'h0,
                    2'b01, 17'h100, 2'b00, 17'h0, 1'b0, 64'h0, 1'b0};
        vecs[4] = '{1'b1, 22'h20010, 8'hFF, 64'h0000_0000_0000_CAFE, 1'b1, 22'h20010,
                    2'b00, 17'h0, 2'b00, 17'h0, 1'b0, 64'h0, 1'b0};
        vecs[5] = '{1'b1, 22'hE0000, 8'hFF, 64'h1, 1'b1, 22'hC0040,
                    2'b10, 17'h0, 2'b01, 17'h40, 1'b1, 64'hB000_0000_0000_0040, 1'b0};
        vecs[6] = '{1'b1, 22'hE0000, 8'h03, 64'h2, 1'b1, 22'hE0040,
                    2'b10, 17'h0, 2'b00, 17'h0, 1'b0, 64'h0, 1'b1};
        vecs[7] = '{1'b1, 22'hC0000, 8'hFF, 64'h3, 1'b1, 22'hE0040,
                    2'b01, 17'h0, 2'b10, 17'h40, 1'b1, 64'hB001_0000_0000_0040, 1'b1};
        vecs[8] = '{1'b0, 22'hE0010, 8'hFF, 64'h4, 1'b0, 22'hC0008,
                    2'b00, 17'h0, 2'b00, 17'h0, 1'b0, 64'h0, 1'b1};

        stream_addr[0] = 22'hC0008; stream_exp[0] = 64'hA5A5;
        stream_addr[1] = 22'hE0018; stream_exp[1] = 64'hB001_0000_0000_0018;
        stream_addr[2] = 22'hC0028; stream_exp[2] = 64'hB000_0000_0000_0028;
        stream_addr[3] = 22'hE0038; stream_exp[3] = 64'hB001_0000_0000_0038;

        // Reset with random inputs held for two cycles.
        glb_tile_id = 4'd3;
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            wr_pkt = {$urandom, $urandom, $urandom, $urandom};
            rd_pkt = {$urandom};
            @(posedge clk);
        end
        #1;
        check("rst_bank_wr_en", 64'(bank_wr_en), 64'h0);
        check("rst_bank_wr_strb", 64'(bank_wr_strb), 64'h0);
        check("rst_bank_wr_addr", 64'(bank_wr_addr), 64'h0);
        check("rst_bank_wr_data", bank_wr_data, 64'h0);
        check("rst_bank_rd_en", 64'(bank_rd_en), 64'h0);
        check("rst_bank_rd_addr", 64'(bank_rd_addr), 64'h0);
        check("rst_rd_data_valid", 64'(rs_pkt.rd_data_valid), 64'h0);
        check("rst_rd_data", rs_pkt.rd_data, 64'h0);
        check("rst_err_collision", 64'(err_collision), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        idle_inputs();
        @(negedge clk);

        // Table: one-cycle packet, then watch the following cycles for the response.
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            wr_pkt = '{wr_en: vecs[v].we, wr_strb: vecs[v].ws, wr_addr: vecs[v].wa, wr_data: vecs[v].wd};
            rd_pkt = '{rd_en: vecs[v].re, rd_addr: vecs[v].ra};
            @(posedge clk);
            #1;
            check($sformatf("v%0d_bank_wr_en", v), 64'(bank_wr_en), 64'(vecs[v].x_wen));
            check($sformatf("v%0d_bank_rd_en", v), 64'(bank_rd_en), 64'(vecs[v].x_ren));
            if (vecs[v].x_wen != 2'b00) begin
                check($sformatf("v%0d_bank_wr_addr", v), 64'(bank_wr_addr), 64'(vecs[v].x_waddr));
                check($sformatf("v%0d_bank_wr_strb", v), 64'(bank_wr_strb), 64'(vecs[v].ws));
                check($sformatf("v%0d_bank_wr_data", v), bank_wr_data, vecs[v].wd);
            end else begin
                check($sformatf("v%0d_bank_wr_data_idle", v), bank_wr_data, 64'h0);
            end
            if (vecs[v].x_ren != 2'b00) begin
                check($sformatf("v%0d_bank_rd_addr", v), 64'(bank_rd_addr), 64'(vecs[v].x_raddr));
            end else begin
                check($sformatf("v%0d_no_rd", v), 64'(bank_rd_en), 64'h0);
            end
            @(negedge clk);
            idle_inputs();
            for (int k = 2; k <= 6; k++) begin
                @(posedge clk);
                #1;
                if (k == 2) begin
                    check($sformatf("v%0d_wr_en_drop", v), 64'(bank_wr_en), 64'h0);
                    check($sformatf("v%0d_rd_en_drop", v), 64'(bank_rd_en), 64'h0);
                end else if (k == 5) begin
                    check($sformatf("v%0d_rd_valid", v), 64'(rs_pkt.rd_data_valid), 64'(vecs[v].x_rv));
                    if (vecs[v].x_rv) begin
                        check($sformatf("v%0d_rd_data", v), rs_pkt.rd_data, vecs[v].x_rdata);
                    end
                end else begin
                    check($sformatf("v%0d_rd_valid_k%0d", v, k), 64'(rs_pkt.rd_data_valid), 64'h0);
                end
            end
            check($sformatf("v%0d_err_collision", v), 64'(err_collision), 64'(vecs[v].x_err));
        end

        // Reset two cycles after an accepted read: no response, sticky error cleared.
        @(negedge clk);
        rd_pkt = '{rd_en: 1'b1, rd_addr: 22'hC0008};
        @(posedge clk);
        #1;
        check("mid_bank_rd_en", 64'(bank_rd_en), 64'h1);
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen_valid = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (rs_pkt.rd_data_valid !== 1'b0) seen_valid = 1'b1;
        end
        check("mid_no_response", 64'(seen_valid), 64'h0);
        check("mid_err_cleared", 64'(err_collision), 64'h0);

        // Four back-to-back reads alternating banks.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (c < 4) rd_pkt = '{rd_en: 1'b1, rd_addr: stream_addr[c]};
            else       idle_inputs();
            @(posedge clk);
            #1;
            if (c >= 4 && c <= 7) begin
                check($sformatf("stream_valid_%0d", c - 4), 64'(rs_pkt.rd_data_valid), 64'h1);
                check($sformatf("stream_data_%0d", c - 4), rs_pkt.rd_data, stream_exp[c-4]);
            end else begin
                check($sformatf("stream_idle_c%0d", c), 64'(rs_pkt.rd_data_valid), 64'h0);
            end
        end
        check("stream_err_collision", 64'(err_collision), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
